seven_segment_bcd_scanner: RTL and testbench

//   Multi-digit BCD up/down counter with time-multiplexed seven-segment drive.
//   - A prescaler generates a count tick every TICK_COUNT enabled cycles.
//   - The digit chain counts in BCD; one digit is driven at a time on a shared segment bus.
//   - Sits between the board clock and the display pins; display digits share one led_out.

---
 rtl/seven_segment_bcd_scanner.sv | 162 ++++++++++++++++
 tb/tb_seven_segment_bcd_scanner.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_bcd_scanner.sv
// seven_segment_bcd_scanner
//   Multi-digit BCD up/down counter with a time-multiplexed seven-segment drive.
//   A prescaler produces one count tick every TICK_COUNT enabled cycles; the digit
//   chain counts in BCD on each tick; a free-running scanner selects one digit at a
//   time onto the shared segment bus.
//   Optional feature macro: SEVSEG_BLANK_LEADING_EN (blank leading zero digits).
module seven_segment_bcd_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_COUNT = 1000,
  parameter int SCAN_COUNT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  up_down,
  input  logic                  clear,
  output logic [6:0]            led_out,
  output logic [NUM_DIGITS-1:0] digit_sel,
  output logic                  rollover
);

  localparam int PW = $clog2(TICK_COUNT);
  localparam int SW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [3:0]    digit_q [NUM_DIGITS];
  logic [3:0]    digit_d [NUM_DIGITS];
  logic [NUM_DIGITS:0] carry;
  logic          rollover_q, rollover_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          scan_wrap;
  logic [3:0]    sel_digit;
  logic          blank;
  logic [6:0]    led_q, led_d;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    seg_encode = 7'b0111111;
      4'd1:    seg_encode = 7'b0000110;
      4'd2:    seg_encode = 7'b1011011;
      4'd3:    seg_encode = 7'b1001111;
      4'd4:    seg_encode = 7'b1100110;
      4'd5:    seg_encode = 7'b1101101;
      4'd6:    seg_encode = 7'b1111101;
      4'd7:    seg_encode = 7'b0000111;
      4'd8:    seg_encode = 7'b1111111;
      4'd9:    seg_encode = 7'b1101111;
      default: seg_encode = 7'b0000000;
    endcase
  endfunction

  assign tick = ena && (presc_q == PW'(TICK_COUNT - 1));

  // Prescaler next state: clear wins, wrap on the tick, hold while disabled.
  always_comb begin
    presc_d = presc_q;
    if (clear)
      presc_d = '0;
    else if (tick)
      presc_d = '0;
    else if (ena)
      presc_d = presc_q + PW'(1);
  end

  // Ripple carry/borrow chain: a digit moves when every digit below it sits at
  // its wrap value (9 going up, 0 going down).
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic at_edge;
      logic [3:0] stepped;
      assign at_edge   = up_down ? (digit_q[gi] == 4'd9) : (digit_q[gi] == 4'd0);
      assign carry[gi+1] = carry[gi] & at_edge;
      assign stepped   = at_edge ? (up_down ? 4'd0 : 4'd9)
                                 : (up_down ? digit_q[gi] + 4'd1 : digit_q[gi] - 4'd1);
      assign digit_d[gi] = clear               ? 4'd0 :
                           (tick && carry[gi]) ? stepped : digit_q[gi];
    end
  endgenerate

  // The full chain wrapping means every digit wrapped on this tick.
  assign rollover_d = !clear && tick && carry[NUM_DIGITS];

  // Scan counter and digit index; independent of ena and clear.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SW'(SCAN_COUNT - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_wrap)
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

`ifdef SEVSEG_BLANK_LEADING_EN
  // upper_zero[k] is set when digit k and everything above it are zero.
  logic [NUM_DIGITS:1] upper_zero;
  assign upper_zero[NUM_DIGITS] = (digit_d[NUM_DIGITS-1] == 4'd0);
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
      assign upper_zero[gi] = upper_zero[gi+1] & (digit_d[gi-1+1] == 4'd0);
    end
  endgenerate
`endif

  // Pick the selected digit's post-update value and encode it for the bus.
  always_comb begin
    sel_digit = 4'd0;
    blank     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i))
        sel_digit = digit_d[i];
    end
`ifdef SEVSEG_BLANK_LEADING_EN
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i) && upper_zero[i])
        blank = 1'b1;
    end
`endif
    led_d = blank ? 7'b0000000 : seg_encode(sel_digit);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      rollover_q <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      led_q      <= 7'b0111111;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 4'd0;
    end else begin
      presc_q    <= presc_d;
      rollover_q <= rollover_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      led_q      <= led_d;
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= digit_d[i];
    end
  end

  generate
    if (NUM_DIGITS == 1) begin : g_sel_single
      assign digit_sel = 1'b1;
    end else begin : g_sel_multi
      logic [NUM_DIGITS-1:0] sel_q;
      // One-hot select registered on the same edge as led_out.
      always_ff @(posedge clk) begin
        if (rst)
          sel_q <= NUM_DIGITS'(1);
        else
          sel_q <= NUM_DIGITS'(1) << idx_q;
      end
      assign digit_sel = sel_q;
    end
  endgenerate

  assign led_out  = led_q;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_seven_segment_bcd_scanner.sv
// Directed bench for seven_segment_bcd_scanner (4 digits, tick every 4, scan every 2).
module tb_seven_segment_bcd_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b0;
  logic       up_down = 1'b1;
  logic       clear = 1'b0;
  logic [6:0] led_out;
  logic [3:0] digit_sel;
  logic       rollover;

  int checks = 0;
  int failures = 0;
  int roll_cnt = 0;
  int cyc = 0;

  seven_segment_bcd_scanner #(
    .NUM_DIGITS(4), .TICK_COUNT(4), .SCAN_COUNT(2)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .up_down(up_down), .clear(clear),
    .led_out(led_out), .digit_sel(digit_sel), .rollover(rollover)
  );

  always #5 clk = ~clk;

  // Cycles since the last reset edge, used by the scan model.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [3:0] exp_sel(input int c);
    int k;
    k = (c == 0) ? 0 : (((c - 1) / 2) % 4);
    exp_sel = 4'(1 << k);
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b0111111;  1: seg_of = 7'b0000110;
      2: seg_of = 7'b1011011;  3: seg_of = 7'b1001111;
      4: seg_of = 7'b1100110;  5: seg_of = 7'b1101101;
      6: seg_of = 7'b1111101;  7: seg_of = 7'b0000111;
      8: seg_of = 7'b1111111;  9: seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction

  function automatic logic [3:0] dig_of(input logic [6:0] s);
    dig_of = 4'hF;
    if (s === 7'b0000000) dig_of = 4'd0;
    for (int d = 0; d < 10; d++)
      if (s === seg_of(d)) dig_of = 4'(d);
  endfunction

  function automatic logic [15:0] bcd_of(input logic [27:0] s);
    for (int k = 0; k < 4; k++) bcd_of[k*4 +: 4] = dig_of(s[k*7 +: 7]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rollover === 1'b1) roll_cnt++;
  endtask

  task automatic run_ticks(input int n, input logic dir);
    ena = 1'b1;
    up_down = dir;
    repeat (4 * n) step();
    ena = 1'b0;
  endtask

  // Walk one full scan with the count frozen, checking the select pattern each cycle.
  task automatic read_segs(output logic [27:0] s);
    s = '1;
    ena = 1'b0;
    repeat (8) begin
      step();
      checks++;
      if (digit_sel !== exp_sel(cyc)) begin
        failures++;
        $display("FAIL scan_sel cyc=%0d got=%b want=%b", cyc, digit_sel, exp_sel(cyc));
      end
      for (int k = 0; k < 4; k++)
        if (digit_sel === 4'(1 << k)) s[k*7 +: 7] = led_out;
    end
  endtask

  task automatic expect_count(input string name, input logic [15:0] want);
    logic [27:0] s;
    read_segs(s);
    checks++;
    if (bcd_of(s) !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, bcd_of(s), want);
    end else
      $display("count %s = %h", name, want);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks += 3;
    if (digit_sel !== 4'b0001) begin failures++; $display("FAIL reset_sel got=%b want=0001", digit_sel); end
    if (led_out !== 7'b0111111) begin failures++; $display("FAIL reset_led got=%b want=0111111", led_out); end
    if (rollover !== 1'b0) begin failures++; $display("FAIL reset_roll got=%b want=0", rollover); end
    rst = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks += 2;
      if (digit_sel !== exp_sel(c)) begin
        failures++; $display("FAIL idle_sel c=%0d got=%b want=%b", c, digit_sel, exp_sel(c));
      end
      if (led_out !== 7'b0111111) begin
        failures++; $display("FAIL idle_led c=%0d got=%b want=0111111", c, led_out);
      end
    end
    $display("reset and idle scan done");
  endtask

  task automatic test_up_count();
    logic [27:0] s;
    roll_cnt = 0;
    run_ticks(10, 1'b1);
    read_segs(s);
    checks += 4;
    if (bcd_of(s) !== 16'h0010) begin failures++; $display("FAIL up_count got=%h want=0010", bcd_of(s)); end
    if (s[13:7] !== 7'b0000110) begin failures++; $display("FAIL up_dig1 got=%b want=0000110", s[13:7]); end
    if (s[6:0] !== 7'b0111111) begin failures++; $display("FAIL up_dig0 got=%b want=0111111", s[6:0]); end
    if (roll_cnt !== 0) begin failures++; $display("FAIL up_noroll got=%0d want=0", roll_cnt); end
    $display("up count 0010 checked");
  endtask

  task automatic test_down();
    run_ticks(90, 1'b1);
    expect_count("to_0100", 16'h0100);
    run_ticks(1, 1'b0);
    expect_count("borrow_0099", 16'h0099);
    roll_cnt = 0;
    run_ticks(99, 1'b0);
    expect_count("down_0000", 16'h0000);
    checks++;
    if (roll_cnt !== 0) begin failures++; $display("FAIL down_noroll got=%0d want=0", roll_cnt); end
    run_ticks(1, 1'b0);
    expect_count("down_wrap_9999", 16'h9999);
    checks++;
    if (roll_cnt !== 1) begin failures++; $display("FAIL down_roll got=%0d want=1", roll_cnt); end
  endtask

  task automatic test_up_wrap();
    roll_cnt = 0;
    run_ticks(1, 1'b1);
    expect_count("up_wrap_0000", 16'h0000);
    checks++;
    if (roll_cnt !== 1) begin failures++; $display("FAIL up_roll cycles got=%0d want=1", roll_cnt); end
  endtask

  task automatic test_clear_on_tick();
    run_ticks(42, 1'b1);
    expect_count("to_0042", 16'h0042);
    roll_cnt = 0;
    ena = 1'b1;
    up_down = 1'b1;
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    ena = 1'b0;
    checks += 3;
    if (dut.presc_q !== 2'd0) begin failures++; $display("FAIL clear_presc got=%0d want=0", dut.presc_q); end
    if (rollover !== 1'b0) begin failures++; $display("FAIL clear_roll got=%b want=0", rollover); end
    if (digit_sel !== exp_sel(cyc)) begin
      failures++; $display("FAIL clear_scan got=%b want=%b", digit_sel, exp_sel(cyc));
    end
    expect_count("after_clear", 16'h0000);
    checks++;
    if (roll_cnt !== 0) begin failures++; $display("FAIL clear_noroll got=%0d want=0", roll_cnt); end
  endtask

  task automatic test_rst_mid();
    run_ticks(3, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    step();
    checks += 2;
    if (digit_sel !== 4'b0001) begin failures++; $display("FAIL rst_mid_sel got=%b want=0001", digit_sel); end
    if (led_out !== 7'b0111111) begin failures++; $display("FAIL rst_mid_led got=%b want=0111111", led_out); end
    rst = 1'b0;
    expect_count("after_rst", 16'h0000);
  endtask

  task automatic test_blank();
    logic [27:0] s;
    logic [6:0]  upper_zero_seg;
`ifdef SEVSEG_BLANK_LEADING_EN
    upper_zero_seg = 7'b0000000;
`else
    upper_zero_seg = 7'b0111111;
`endif
    run_ticks(7, 1'b1);
    read_segs(s);
    checks += 4;
    if (s[6:0] !== 7'b0000111) begin failures++; $display("FAIL blank7_dig0 got=%b want=0000111", s[6:0]); end
    for (int k = 1; k < 4; k++)
      if (s[k*7 +: 7] !== upper_zero_seg) begin
        failures++; $display("FAIL blank7_dig%0d got=%b want=%b", k, s[k*7 +: 7], upper_zero_seg);
      end
    clear = 1'b1;
    step();
    clear = 1'b0;
    read_segs(s);
    checks += 4;
    if (s[6:0] !== 7'b0111111) begin failures++; $display("FAIL blank0_dig0 got=%b want=0111111", s[6:0]); end
    for (int k = 1; k < 4; k++)
      if (s[k*7 +: 7] !== upper_zero_seg) begin
        failures++; $display("FAIL blank0_dig%0d got=%b want=%b", k, s[k*7 +: 7], upper_zero_seg);
      end
    $display("leading digit display checked");
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down();
    test_up_wrap();
    test_clear_on_tick();
    test_rst_mid();
    test_blank();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
